// File: rtl/stage2_stream_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : stage2_stream_wb_if
// Brief    : Request, stream and read-back bundle of the stream writeback unit.
// Revision : 1.0 - initial release
// ============================================================================
interface stage2_stream_wb_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int CHANNELS       = 2,
   parameter int CHAN_WIDTH     = 1,
   parameter int WAIT_CNT_WIDTH = 6
);
   logic                           prev_vld;
   logic                           rdy;
   logic [1:0]                     op;
   logic [CHAN_WIDTH-1:0]          chan;
   logic [DATA_WIDTH-1:0]          wr_data;
   logic                           wr_last;
   logic [CHANNELS*DATA_WIDTH-1:0] din_TDATA;
   logic [CHANNELS-1:0]            din_TLAST;
   logic [CHANNELS-1:0]            din_TVALID;
   logic [CHANNELS-1:0]            din_TREADY;
   logic [DATA_WIDTH-1:0]          dout_TDATA;
   logic                           dout_TLAST;
   logic [CHANNELS-1:0]            dout_TVALID;
   logic [CHANNELS-1:0]            dout_TREADY;
   logic [DATA_WIDTH-1:0]          rd_data;
   logic                           rd_last;
   logic                           rd_vld;
   logic                           chan_err;
   logic [WAIT_CNT_WIDTH-1:0]      wait_cnt;
   logic                           timeout;

   modport master (
      output prev_vld, op, chan, wr_data, wr_last,
      output din_TDATA, din_TLAST, din_TVALID, dout_TREADY,
      input  rdy, din_TREADY, dout_TDATA, dout_TLAST, dout_TVALID,
      input  rd_data, rd_last, rd_vld, chan_err, wait_cnt, timeout
   );

   modport slave (
      input  prev_vld, op, chan, wr_data, wr_last,
      input  din_TDATA, din_TLAST, din_TVALID, dout_TREADY,
      output rdy, din_TREADY, dout_TDATA, dout_TLAST, dout_TVALID,
      output rd_data, rd_last, rd_vld, chan_err, wait_cnt, timeout
   );
endinterface
`default_nettype wire

// File: rtl/stage2_stream_wb.sv
`default_nettype none
// ============================================================================
// Module   : stage2_stream_wb
// Brief    : Multi-channel stream writeback: posted 1-deep OUT buffer, registered
//            IN capture, saturating stall counter, channel range check.
//            Optional IN timeout enabled by macro STAGE2_STREAM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stage2_stream_wb #(
   parameter int DATA_WIDTH     = 32,
   parameter int CHANNELS       = 2,
   parameter int CHAN_WIDTH     = 1,
   parameter int WAIT_CNT_WIDTH = 6,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  wire logic          clk,
   input  wire logic          rst,
   stage2_stream_wb_if.slave  bus
);

   localparam logic [1:0] c_op_in  = 2'd1;
   localparam logic [1:0] c_op_out = 2'd2;

   if ((TIMEOUT_CYCLES < 1) || ((2 ** CHAN_WIDTH) < CHANNELS)) begin : g_param_check
      $error("stage2_stream_wb: illegal TIMEOUT_CYCLES or CHAN_WIDTH too small");
   end

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      IN_WAIT = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [CHAN_WIDTH-1:0]     in_chan_q, in_chan_d;
   logic                      ob_full_q, ob_full_d;
   logic [CHAN_WIDTH-1:0]     ob_chan_q, ob_chan_d;
   logic [DATA_WIDTH-1:0]     ob_data_q, ob_data_d;
   logic                      ob_last_q, ob_last_d;
   logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
   logic                      rd_last_q, rd_last_d;
   logic                      rd_vld_q, rd_vld_d;
   logic                      chan_err_q, chan_err_d;
   logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

   logic                      w_drain;
   logic                      w_rdy;
   logic                      w_acc;
   logic                      w_chan_ok;
   logic                      w_in_vld;
   logic [DATA_WIDTH-1:0]     w_in_data;
   logic                      w_in_last;
   logic [CHANNELS-1:0]       w_din_rdy;
   logic [CHANNELS-1:0]       w_dout_vld;

`ifdef STAGE2_STREAM_TIMEOUT_EN
   localparam int c_to_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   logic [c_to_w-1:0] to_cnt_q, to_cnt_d;
   logic              timeout_q, timeout_d;
`endif

   // Per-channel muxing keyed on registered channel indices only
   always_comb begin
      w_drain    = 1'b0;
      w_in_vld   = 1'b0;
      w_in_data  = '0;
      w_in_last  = 1'b0;
      w_din_rdy  = '0;
      w_dout_vld = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (ob_chan_q == CHAN_WIDTH'(c)) begin
            w_drain       = ob_full_q && bus.dout_TREADY[c];
            w_dout_vld[c] = ob_full_q;
         end
         if (in_chan_q == CHAN_WIDTH'(c)) begin
            w_in_vld     = bus.din_TVALID[c];
            w_in_data    = bus.din_TDATA[c*DATA_WIDTH +: DATA_WIDTH];
            w_in_last    = bus.din_TLAST[c];
            w_din_rdy[c] = (state_q == IN_WAIT);
         end
      end
   end

   assign w_chan_ok = (32'(bus.chan) < CHANNELS);
   assign w_rdy     = (state_q == IDLE) && !((bus.op == c_op_out) && ob_full_q && !w_drain);
   assign w_acc     = bus.prev_vld && w_rdy;

   always_comb begin
      state_d    = state_q;
      in_chan_d  = in_chan_q;
      ob_full_d  = ob_full_q;
      ob_chan_d  = ob_chan_q;
      ob_data_d  = ob_data_q;
      ob_last_d  = ob_last_q;
      rd_data_d  = rd_data_q;
      rd_last_d  = rd_last_q;
      rd_vld_d   = 1'b0;
      chan_err_d = 1'b0;
      wait_cnt_d = wait_cnt_q;
`ifdef STAGE2_STREAM_TIMEOUT_EN
      to_cnt_d   = '0;
      timeout_d  = 1'b0;
`endif

      // A load in the same cycle as a drain simply replaces the flit
      if (w_drain) begin
         ob_full_d = 1'b0;
      end

      if (w_acc) begin
         wait_cnt_d = '0;
         if ((bus.op == c_op_in) || (bus.op == c_op_out)) begin
            if (!w_chan_ok) begin
               chan_err_d = 1'b1;
            end else if (bus.op == c_op_out) begin
               ob_full_d = 1'b1;
               ob_chan_d = bus.chan;
               ob_data_d = bus.wr_data;
               ob_last_d = bus.wr_last;
            end else begin
               state_d   = IN_WAIT;
               in_chan_d = bus.chan;
            end
         end
      end else if ((state_q == IN_WAIT) || bus.prev_vld) begin
         if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_WIDTH'(1);
         end
      end

      if (state_q == IN_WAIT) begin
         if (w_in_vld) begin
            state_d   = IDLE;
            rd_vld_d  = 1'b1;
            rd_data_d = w_in_data;
            rd_last_d = w_in_last;
         end
`ifdef STAGE2_STREAM_TIMEOUT_EN
         else if (to_cnt_q == c_to_w'(TIMEOUT_CYCLES - 1)) begin
            state_d   = IDLE;
            rd_vld_d  = 1'b1;
            rd_data_d = '0;
            rd_last_d = 1'b1;
            timeout_d = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + c_to_w'(1);
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         in_chan_q  <= '0;
         ob_full_q  <= 1'b0;
         ob_chan_q  <= '0;
         ob_data_q  <= '0;
         ob_last_q  <= 1'b0;
         rd_data_q  <= '0;
         rd_last_q  <= 1'b0;
         rd_vld_q   <= 1'b0;
         chan_err_q <= 1'b0;
         wait_cnt_q <= '0;
`ifdef STAGE2_STREAM_TIMEOUT_EN
         to_cnt_q   <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         in_chan_q  <= in_chan_d;
         ob_full_q  <= ob_full_d;
         ob_chan_q  <= ob_chan_d;
         ob_data_q  <= ob_data_d;
         ob_last_q  <= ob_last_d;
         rd_data_q  <= rd_data_d;
         rd_last_q  <= rd_last_d;
         rd_vld_q   <= rd_vld_d;
         chan_err_q <= chan_err_d;
         wait_cnt_q <= wait_cnt_d;
`ifdef STAGE2_STREAM_TIMEOUT_EN
         to_cnt_q   <= to_cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign bus.rdy         = w_rdy;
   assign bus.din_TREADY  = w_din_rdy;
   assign bus.dout_TVALID = w_dout_vld;
   assign bus.dout_TDATA  = ob_data_q;
   assign bus.dout_TLAST  = ob_last_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.rd_last     = rd_last_q;
   assign bus.rd_vld      = rd_vld_q;
   assign bus.chan_err    = chan_err_q;
   assign bus.wait_cnt    = wait_cnt_q;
`ifdef STAGE2_STREAM_TIMEOUT_EN
   assign bus.timeout     = timeout_q;
`else
   assign bus.timeout     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage2_stream_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage2_stream_wb
// Brief    : Scoreboard bench for stage2_stream_wb (3 channels); timeout cases
//            compile only with STAGE2_STREAM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage2_stream_wb;

   localparam int DW  = 32;
   localparam int NCH = 3;
   localparam int CW  = 2;
   localparam int WCW = 6;
   localparam int TO  = 8;
   localparam logic [1:0] c_op_in  = 2'd1;
   localparam logic [1:0] c_op_out = 2'd2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic [CW+DW:0] out_q[$];
   logic [DW:0]    rd_q[$];
   logic [CW+DW:0] oe;
   logic [DW:0]    re;

   stage2_stream_wb_if #(.DATA_WIDTH(DW), .CHANNELS(NCH), .CHAN_WIDTH(CW), .WAIT_CNT_WIDTH(WCW)) bus ();

   stage2_stream_wb #(
      .DATA_WIDTH(DW), .CHANNELS(NCH), .CHAN_WIDTH(CW),
      .WAIT_CNT_WIDTH(WCW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [1:0] o, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic l);
      int n;
      n = 0;
      bus.prev_vld = 1'b1;
      bus.op = o;
      bus.chan = c;
      bus.wr_data = d;
      bus.wr_last = l;
      @(negedge clk);
      while (!bus.rdy && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.rdy) check_val("send_timeout", 64'(bus.rdy), 64'd1);
      else if (o == c_op_out && 32'(c) < NCH) out_q.push_back({c, d, l});
      @(posedge clk);
      #1;
      bus.prev_vld = 1'b0;
      bus.op = 2'd0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < NCH; c++) begin
            if (bus.dout_TVALID[c] && bus.dout_TREADY[c]) begin
               if (out_q.size() == 0) check_val("out_unexpected", 64'd1, 64'd0);
               else begin
                  oe = out_q.pop_front();
                  check_val("out_chan", 64'(c), 64'(oe[CW+DW:DW+1]));
                  check_val("out_data", 64'(bus.dout_TDATA), 64'(oe[DW:1]));
                  check_val("out_last", 64'(bus.dout_TLAST), 64'(oe[0]));
               end
            end
         end
         if (bus.rd_vld) begin
            if (rd_q.size() == 0) check_val("rd_unexpected", 64'd1, 64'd0);
            else begin
               re = rd_q.pop_front();
               check_val("rd_data", 64'(bus.rd_data), 64'(re[DW:1]));
               check_val("rd_last", 64'(bus.rd_last), 64'(re[0]));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.prev_vld = 1'b0; bus.op = 2'd0; bus.chan = '0; bus.wr_data = '0; bus.wr_last = 1'b0;
      bus.din_TDATA = '0; bus.din_TLAST = '0; bus.din_TVALID = '0; bus.dout_TREADY = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("rst_rdy", 64'(bus.rdy), 64'd1);
      check_val("rst_din_tready", 64'(bus.din_TREADY), 64'd0);
      check_val("rst_dout_tvalid", 64'(bus.dout_TVALID), 64'd0);
      check_val("rst_rd_vld", 64'(bus.rd_vld), 64'd0);
      check_val("rst_rd_data", 64'(bus.rd_data), 64'd0);
      check_val("rst_wait_cnt", 64'(bus.wait_cnt), 64'd0);
      check_val("rst_chan_err", 64'(bus.chan_err), 64'd0);
      check_val("rst_timeout", 64'(bus.timeout), 64'd0);

      // Single OUT on channel 1 with its ready already high
      @(posedge clk); #1;
      bus.dout_TREADY = 3'b010;
      send(c_op_out, 2'd1, 32'hDEADBEEF, 1'b1);
      @(negedge clk);
      check_val("out1_tvalid", 64'(bus.dout_TVALID), 64'b010);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("out1_cleared", 64'(bus.dout_TVALID), 64'd0);

      // Back-to-back OUTs with channel 0 stalled for three cycles
      @(posedge clk); #1;
      bus.dout_TREADY = 3'b000;
      send(c_op_out, 2'd0, 32'h1, 1'b0);
      bus.prev_vld = 1'b1; bus.op = c_op_out; bus.chan = 2'd0; bus.wr_data = 32'h2; bus.wr_last = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("bb_stall_rdy", 64'(bus.rdy), 64'd0);
         check_val("bb_wait_cnt", 64'(bus.wait_cnt), 64'(k));
         @(posedge clk); #1;
      end
      bus.dout_TREADY = 3'b001;
      @(negedge clk);
      check_val("bb_rdy_on_drain", 64'(bus.rdy), 64'd1);
      check_val("bb_wait_cnt_3", 64'(bus.wait_cnt), 64'd3);
      out_q.push_back({2'd0, 32'h2, 1'b1});
      @(posedge clk); #1;
      bus.prev_vld = 1'b0; bus.op = 2'd0;
      @(negedge clk);
      check_val("bb_no_gap", 64'(bus.dout_TVALID), 64'b001);
      check_val("bb_wait_cleared", 64'(bus.wait_cnt), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("bb_drained", 64'(bus.dout_TVALID), 64'd0);

      // IN on channel 0, valid arrives 4 cycles later; channel 1 valid is a decoy
      @(posedge clk); #1;
      bus.dout_TREADY = 3'b000;
      bus.din_TVALID = 3'b010;
      bus.din_TDATA[1*DW +: DW] = 32'hAAAA_AAAA;
      send(c_op_in, 2'd0, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_val("in_tready", 64'(bus.din_TREADY), 64'b001);
         check_val("in_no_rd_vld", 64'(bus.rd_vld), 64'd0);
         check_val("in_wait_cnt", 64'(bus.wait_cnt), 64'(k));
         @(posedge clk); #1;
      end
      bus.din_TVALID = 3'b011;
      bus.din_TDATA[0 +: DW] = 32'h55;
      bus.din_TLAST = 3'b001;
      rd_q.push_back({32'h55, 1'b1});
      @(negedge clk);
      check_val("in_tready_hs", 64'(bus.din_TREADY), 64'b001);
      @(posedge clk); #1;
      bus.din_TVALID = 3'b000;
      @(negedge clk);
      check_val("in_rd_vld", 64'(bus.rd_vld), 64'd1);
      check_val("in_tready_drop", 64'(bus.din_TREADY), 64'd0);

      // Minimum IN latency on channel 2 with valid already present
      @(posedge clk); #1;
      bus.din_TDATA[2*DW +: DW] = 32'h1234_5678;
      bus.din_TLAST = 3'b000;
      bus.din_TVALID = 3'b100;
      rd_q.push_back({32'h1234_5678, 1'b0});
      send(c_op_in, 2'd2, 32'h0, 1'b0);
      @(negedge clk);
      check_val("lat_tready", 64'(bus.din_TREADY), 64'b100);
      check_val("lat_rd_vld_early", 64'(bus.rd_vld), 64'd0);
      @(posedge clk); #1;
      bus.din_TVALID = 3'b000;
      bus.din_TDATA = '0;
      @(negedge clk);
      check_val("lat_rd_vld", 64'(bus.rd_vld), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("rd_vld_pulse", 64'(bus.rd_vld), 64'd0);
      check_val("rd_data_hold", 64'(bus.rd_data), 64'h1234_5678);

      // Out-of-range channel for OUT and IN
      @(posedge clk); #1;
      send(c_op_out, 2'd3, 32'h99, 1'b0);
      @(negedge clk);
      check_val("cerr_out_pulse", 64'(bus.chan_err), 64'd1);
      check_val("cerr_out_tvalid", 64'(bus.dout_TVALID), 64'd0);
      check_val("cerr_out_rdy", 64'(bus.rdy), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("cerr_clear", 64'(bus.chan_err), 64'd0);
      @(posedge clk); #1;
      send(c_op_in, 2'd3, 32'h0, 1'b0);
      @(negedge clk);
      check_val("cerr_in_pulse", 64'(bus.chan_err), 64'd1);
      check_val("cerr_in_tready", 64'(bus.din_TREADY), 64'd0);
      check_val("cerr_in_rdy", 64'(bus.rdy), 64'd1);

      // Reset while both a pending OUT flit and an IN wait are live
      @(posedge clk); #1;
      send(c_op_out, 2'd2, 32'h77, 1'b0);
      send(c_op_in, 2'd1, 32'h0, 1'b0);
      bus.prev_vld = 1'b1; bus.op = c_op_out; bus.chan = 2'd2;
      @(negedge clk);
      check_val("prerst_din_tready", 64'(bus.din_TREADY), 64'b010);
      check_val("prerst_dout_tvalid", 64'(bus.dout_TVALID), 64'b100);
      @(posedge clk); #1;
      rst = 1'b1;
      bus.prev_vld = 1'b0; bus.op = 2'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      out_q.delete();
      @(negedge clk);
      check_val("postrst_din_tready", 64'(bus.din_TREADY), 64'd0);
      check_val("postrst_dout_tvalid", 64'(bus.dout_TVALID), 64'd0);
      check_val("postrst_rdy", 64'(bus.rdy), 64'd1);
      check_val("postrst_wait_cnt", 64'(bus.wait_cnt), 64'd0);

`ifdef STAGE2_STREAM_TIMEOUT_EN
      // No valid at all: timeout after TO cycles in IN_WAIT
      @(posedge clk); #1;
      rd_q.push_back({32'h0, 1'b1});
      send(c_op_in, 2'd0, 32'h0, 1'b0);
      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         check_val("to_not_yet", 64'(bus.timeout), 64'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check_val("to_pulse", 64'(bus.timeout), 64'd1);
      check_val("to_rd_vld", 64'(bus.rd_vld), 64'd1);
      check_val("to_tready_drop", 64'(bus.din_TREADY), 64'd0);
      // Handshake in the final cycle beats the timeout
      @(posedge clk); #1;
      send(c_op_in, 2'd0, 32'h0, 1'b0);
      repeat (TO - 1) @(posedge clk);
      #1;
      bus.din_TDATA[0 +: DW] = 32'hC0FFEE;
      bus.din_TLAST = 3'b000;
      bus.din_TVALID = 3'b001;
      rd_q.push_back({32'hC0FFEE, 1'b0});
      @(posedge clk); #1;
      bus.din_TVALID = 3'b000;
      @(negedge clk);
      check_val("to_hs_wins_vld", 64'(bus.rd_vld), 64'd1);
      check_val("to_hs_wins_to", 64'(bus.timeout), 64'd0);
`endif

      @(posedge clk); #1;
      @(negedge clk);
      check_val("out_queue_empty", 64'(out_q.size()), 64'd0);
      check_val("rd_queue_empty", 64'(rd_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stage2_stream_wb.md
Name: stage2_stream_wb

Overview:
- Multi-channel stream writeback unit for the axis_cpu controller; generalises the single din/dout stream handling of the writeback stage to CHANNELS input and CHANNELS output AXI-Stream ports.
- Adds a posted, 1-deep output holding buffer, a registered input capture path, a saturating wait-cycle counter and channel-range checking.
- Sits between the writeback-stage decode and the external streams; its rd_* outputs feed the A/X load muxes in the datapath.

Parameters:
DATA_WIDTH, 32, width of stream data and of wr_data/rd_data
CHANNELS, 2, number of input and number of output stream channels (>=1)
CHAN_WIDTH, 1, width of chan; must satisfy 2**CHAN_WIDTH >= CHANNELS
WAIT_CNT_WIDTH, 6, width of wait_cnt
TIMEOUT_CYCLES, 255, IN_WAIT limit; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
prev_vld  in  1  request valid from previous stage
rdy  out  1  request accepted when prev_vld && rdy
op  in  2  0=NOP, 1=IN, 2=OUT, 3=NOP
chan  in  CHAN_WIDTH  stream channel index
wr_data  in  DATA_WIDTH  OUT payload (A or X)
wr_last  in  1  OUT TLAST value
din_TDATA  in  CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
din_TLAST  in  CHANNELS  per-channel TLAST
din_TVALID  in  CHANNELS  per-channel valid
din_TREADY  out  CHANNELS  per-channel ready
dout_TDATA  out  DATA_WIDTH  shared by all output channels
dout_TLAST  out  1  shared by all output channels
dout_TVALID  out  CHANNELS  per-channel valid
dout_TREADY  in  CHANNELS  per-channel ready
rd_data  out  DATA_WIDTH  captured IN data
rd_last  out  1  captured IN TLAST
rd_vld  out  1  1-cycle pulse; rd_data/rd_last are valid
chan_err  out  1  1-cycle pulse; accepted IN/OUT had chan >= CHANNELS
wait_cnt  out  WAIT_CNT_WIDTH  stall cycles of the current request
timeout  out  1  1-cycle pulse on IN timeout

Behaviour:
- Reset: state=IDLE, ob_full=0, rd_vld=0, rd_data=0, rd_last=0, chan_err=0, wait_cnt=0, timeout=0; all din_TREADY and dout_TVALID bits are 0. A flit pending at reset is abandoned without a handshake.
- States: IDLE, IN_WAIT. The output buffer (ob_full, ob_chan, ob_data, ob_last) is independent of the state.
- drain = ob_full && dout_TREADY[ob_chan].
- rdy = (state==IDLE) && !(op==OUT && ob_full && !drain). Combinational path dout_TREADY->rdy is permitted.
- Accept NOP: no effect other than clearing wait_cnt.
- Accept with chan >= CHANNELS and op IN or OUT: treated as NOP; chan_err pulses next cycle.
- Accept OUT: next cycle ob_full=1, ob_chan=chan, ob_data=wr_data, ob_last=wr_last. Simultaneous drain and load leaves ob_full=1 holding the new data.
- Drain without load: ob_full=0 next cycle.
- dout_TVALID[c] = ob_full && ob_chan==c. dout_TDATA=ob_data, dout_TLAST=ob_last. These outputs depend only on registers.
- Accept IN: next cycle state=IN_WAIT with channel latched.
- IN_WAIT: din_TREADY[latched chan]=1, all other bits 0; din_TREADY depends only on registers.
- IN_WAIT handshake (din_TVALID[latched chan]=1): next cycle rd_data/rd_last take that channel's TDATA/TLAST, rd_vld=1 and state=IDLE. Minimum IN latency: accept to rd_vld = 2 cycles.
- rd_data and rd_last hold their value until the next capture.
- IN and OUT are independent: a pending output flit does not block IN.
- wait_cnt:
  - Clears on every accept.
  - Otherwise increments each cycle the unit is in IN_WAIT, or in IDLE with prev_vld && !rdy.
  - Saturates at all-ones; it never wraps.

Optional Feature:
- Macro STAGE2_STREAM_TIMEOUT_EN.
- Defined: an internal TIMEOUT_CYCLES-wide-enough counter counts cycles spent in IN_WAIT.
  - If TIMEOUT_CYCLES cycles pass with no handshake, next cycle state=IDLE, rd_vld=1, rd_data=0, rd_last=1, timeout=1, and din_TREADY drops.
  - A handshake in the final cycle wins over the timeout.
- Not defined: timeout is tied to 0 and IN_WAIT is held indefinitely.

Test Plan:
- OUT chan=1, wr_data=0xDEADBEEF, wr_last=1, dout_TREADY=2'b10 -> next cycle dout_TVALID=2'b10, TDATA=0xDEADBEEF, TLAST=1; ob_full clears the cycle after.
- Back-to-back OUTs 0x1, 0x2 on chan=0 with dout_TREADY[0]=0 for 3 cycles -> rdy=0 for 3 cycles, wait_cnt reaches 3, 0x1 then 0x2 delivered in order with no gap.
- IN chan=0, din_TVALID[0] raised 4 cycles later with data 0x55, TLAST=1 -> din_TREADY=2'b01 throughout, rd_vld one cycle after the handshake, rd_data=0x55, rd_last=1.
- CHANNELS=3, OUT chan=3 -> chan_err pulse, no dout_TVALID, rdy stays 1.
- rst asserted while in IN_WAIT and while ob_full=1 -> next cycle all TREADY/TVALID bits 0, rdy=1, wait_cnt=0.
- With STAGE2_STREAM_TIMEOUT_EN, TIMEOUT_CYCLES=8: IN with no input valid -> after 8 cycles timeout=1, rd_vld=1, rd_data=0; second run with handshake at cycle 8 -> real data, timeout=0.
